// File: rtl/conv_enc_k3_tx_if.sv
// rtl/conv_enc_k3_tx_if.sv - handshake bundle between bit source, encoder and pair sink
interface conv_enc_k3_tx_if;
    logic       start;
    logic       in_bit;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] tx_pair;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_last;
    logic       busy;
    logic       frame_done;

    // Encoder side
    modport slave (
        input  start, in_bit, in_valid, tx_ready,
        output in_ready, tx_pair, tx_valid, tx_last, busy, frame_done
    );

    // Source/sink side
    modport master (
        output start, in_bit, in_valid, tx_ready,
        input  in_ready, tx_pair, tx_valid, tx_last, busy, frame_done
    );
endinterface

// File: rtl/conv_enc_k3_tx.sv
// rtl/conv_enc_k3_tx.sv - rate-1/2 K=3 convolutional encoder with zero-tail termination
module conv_enc_k3_tx #(
    parameter int         FRAME_LEN = 8,
    parameter logic [2:0] G0        = 3'b111,
    parameter logic [2:0] G1        = 3'b101
) (
    input logic             clk,
    input logic             rst,
    conv_enc_k3_tx_if.slave bus
);
    localparam int CW = $clog2(FRAME_LEN + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DATA  = 2'd1;
    localparam logic [1:0] S_TAIL  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [1:0]    sr_q, sr_d;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic          tail_cnt_q, tail_cnt_d;
    logic [1:0]    tx_pair_q, tx_pair_d;
    logic          tx_valid_q, tx_valid_d;
    logic          tx_last_q, tx_last_d;

    logic adv;
    logic in_ready;
    logic accept;
    logic last_hs;

    // Vector is {current input, newest stored bit, oldest stored bit}
    function automatic logic [1:0] encode(input logic u, input logic [1:0] sr);
        logic [2:0] v;
        v = {u, sr};
        return {^(v & G0), ^(v & G1)};
    endfunction

    assign adv      = !tx_valid_q || bus.tx_ready;
    assign in_ready = (state_q == S_DATA) && adv;
    assign accept   = in_ready && bus.in_valid;
    assign last_hs  = tx_valid_q && bus.tx_ready && tx_last_q;

    // Next-state logic: frame sequencing and output register loading
    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        bit_cnt_d  = bit_cnt_q;
        tail_cnt_d = tail_cnt_q;
        tx_pair_d  = tx_pair_q;
        tx_valid_d = tx_valid_q;
        tx_last_d  = tx_last_q;

        // A consumed pair empties the register unless something reloads it below
        if (tx_valid_q && bus.tx_ready) begin
            tx_valid_d = 1'b0;
            tx_last_d  = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    sr_d       = 2'b00;
                    bit_cnt_d  = '0;
                    tail_cnt_d = 1'b0;
                    state_d    = S_DATA;
                end
            end
            S_DATA: begin
                if (accept) begin
                    tx_pair_d  = encode(bus.in_bit, sr_q);
                    tx_valid_d = 1'b1;
                    tx_last_d  = 1'b0;
                    sr_d       = {bus.in_bit, sr_q[1]};
                    bit_cnt_d  = bit_cnt_q + CW'(1);
                    if (bit_cnt_q == LAST_CNT) begin
                        tail_cnt_d = 1'b0;
                        state_d    = S_TAIL;
                    end
                end
            end
            S_TAIL: begin
                if (adv) begin
                    tx_pair_d  = encode(1'b0, sr_q);
                    tx_valid_d = 1'b1;
                    tx_last_d  = tail_cnt_q;
                    sr_d       = {1'b0, sr_q[1]};
                    tail_cnt_d = 1'b1;
                    if (tail_cnt_q) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            default: begin
                if (last_hs) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            sr_q       <= 2'b00;
            bit_cnt_q  <= '0;
            tail_cnt_q <= 1'b0;
            tx_pair_q  <= 2'b00;
            tx_valid_q <= 1'b0;
            tx_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            bit_cnt_q  <= bit_cnt_d;
            tail_cnt_q <= tail_cnt_d;
            tx_pair_q  <= tx_pair_d;
            tx_valid_q <= tx_valid_d;
            tx_last_q  <= tx_last_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.tx_pair    = tx_pair_q;
    assign bus.tx_valid   = tx_valid_q;
    assign bus.tx_last    = tx_last_q;
    assign bus.busy       = (state_q != S_IDLE);
    // Done is flagged on the final handshake itself, not a cycle later
    assign bus.frame_done = !rst && (state_q == S_DRAIN) && last_hs;
endmodule
